note_scroller: RTL and testbench

- Note-sprite stage directly upstream of the rendering colour mux.
- Holds a table of active notes and scrolls every note left by a fixed step once per video frame.
- Per pixel, tells the colour stage whether the current DrawX/DrawY lies inside any note head, via draw_note.
- Runs on the pixel clock, alongside the ledger background generator.

---
 rtl/note_scroller.sv | 159 +++++++++++++++
 tb/tb_note_scroller.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/note_scroller.sv
// Note-sprite stage upstream of the colour mux. A small table of note heads
// is scrolled left by SPEED pixels once per frame, and each pixel reports
// through draw_note whether it falls inside any note head.
`timescale 1ns/1ps
module note_scroller #(
  parameter int NUM_NOTES  = 16,
  parameter int SPEED      = 2,
  parameter int SPAWN_X    = 639,
  parameter int STAFF_TOP  = 160,
  parameter int HALF_SPACE = 5,
  parameter int NOTE_W     = 8,
  parameter int NOTE_H     = 6
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       vs,
  input  logic       blank,
  input  logic [9:0] DrawX,
  input  logic [9:0] DrawY,
  input  logic       note_valid,
  input  logic [3:0] note_pitch,
  output logic       note_ready,
  output logic       draw_note,
  output logic [4:0] active_count
);

  localparam int IDX_W = $clog2(NUM_NOTES);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t               state, state_next;
  logic [IDX_W-1:0]     idx, idx_next;
  logic [IDX_W-1:0]     free_idx;
  logic [NUM_NOTES-1:0] slot_valid;
  logic [9:0]           slot_x     [NUM_NOTES];
  logic [3:0]           slot_pitch [NUM_NOTES];
  logic                 vs_q;
  logic                 frame_tick;
  logic                 accept;
  logic                 scan_valid;
  logic                 retire;
  logic                 shift;
  logic                 any_hit;

  // A note head covers [x, x+NOTE_W-1] by [y_top, y_top+NOTE_H-1]; upper
  // bounds are formed at 11 bits so a note near x=1023 cannot wrap.
  function automatic logic note_hit(input logic       v,
                                    input logic [9:0] x,
                                    input logic [3:0] p,
                                    input logic [9:0] dx,
                                    input logic [9:0] dy);
    logic [9:0] y_top;
    y_top = 10'(STAFF_TOP + 32'(p) * HALF_SPACE);
    return v
        && (dx >= x)     && ({1'b0, dx} <= {1'b0, x}     + 11'(NOTE_W - 1))
        && (dy >= y_top) && ({1'b0, dy} <= {1'b0, y_top} + 11'(NOTE_H - 1));
  endfunction

  assign frame_tick = vs_q & ~vs;

  // Ready only in IDLE with a free slot, and never while reset is held.
  assign note_ready = Reset && (state == IDLE)
                   && ({1'b0, active_count} < 6'(NUM_NOTES));
  assign accept     = note_valid && note_ready;

  assign scan_valid = (state == SCAN) && slot_valid[idx];
  assign retire     = scan_valid && (slot_x[idx] < 10'(SPEED));
  assign shift      = scan_valid && !retire;

  // Remember the previous vs sample to detect its falling edge.
  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) vs_q <= 1'b1;
    else        vs_q <= vs;
  end

  // FSM state and scan index registers.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state <= IDLE;
      idx   <= '0;
    end else begin
      state <= state_next;
      idx   <= idx_next;
    end
  end

  // Next-state logic: a frame tick in IDLE launches a one-slot-per-cycle scan.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_next = state;
    idx_next   = idx;
    unique case (state)
      IDLE: begin
        if (frame_tick) begin
          state_next = SCAN;
          idx_next   = '0;
        end
      end
      SCAN: begin
        idx_next = idx + 1'b1;
        if (idx == IDX_W'(NUM_NOTES - 1)) state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Lowest-index free slot; only consulted when a free slot exists.
  always_comb begin
    free_idx = '0;
    for (int i = NUM_NOTES - 1; i >= 0; i--) begin
      if (!slot_valid[i]) free_idx = IDX_W'(i);
    end
  end

  // Slot valid bits: set on accept, cleared when a scanned note retires.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      slot_valid <= '0;
    end else begin
      if (accept) slot_valid[free_idx] <= 1'b1;
      if (retire) slot_valid[idx]      <= 1'b0;
    end
  end

  // Slot payload: spawn position on accept, scroll left during the scan.
  // NOTE: payload storage has no reset; the valid bits alone decide whether a slot exists.
  always_ff @(posedge Clk) begin
    if (accept) begin
      slot_x[free_idx]     <= 10'(SPAWN_X);
      slot_pitch[free_idx] <= note_pitch;
    end else if (shift) begin
      slot_x[idx] <= slot_x[idx] - 10'(SPEED);
    end
  end

  // Accepts only happen in IDLE and retires only in SCAN, so they never coincide.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset)      active_count <= '0;
    else if (accept) active_count <= active_count + 5'd1;
    else if (retire) active_count <= active_count - 5'd1;
  end

  // OR of per-slot hits for the current pixel.
  always_comb begin
    any_hit = 1'b0;
    for (int i = 0; i < NUM_NOTES; i++) begin
      any_hit = any_hit | note_hit(slot_valid[i], slot_x[i], slot_pitch[i], DrawX, DrawY);
    end
  end

  // One-cycle registered pixel decision, masked by blanking.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) draw_note <= 1'b0;
    else        draw_note <= any_hit & blank;
  end

endmodule

// File: tb/tb_note_scroller.sv
// Randomized scoreboard bench for note_scroller. The driver keeps a
// note-list model (frame update applied as a whole) and queues the expected
// post-edge outputs; a monitor pops and compares one entry per clock.
`timescale 1ns/1ps
module tb_note_scroller;

  localparam int N          = 16;
  localparam int SPEED      = 2;
  localparam int SPAWN_X    = 639;
  localparam int STAFF_TOP  = 160;
  localparam int HALF_SPACE = 5;
  localparam int NOTE_W     = 8;
  localparam int NOTE_H     = 6;

  logic       Clk = 1'b0;
  logic       Reset = 1'b0;
  logic       vs = 1'b1;
  logic       blank = 1'b0;
  logic [9:0] DrawX = '0;
  logic [9:0] DrawY = '0;
  logic       note_valid = 1'b0;
  logic [3:0] note_pitch = '0;
  logic       note_ready;
  logic       draw_note;
  logic [4:0] active_count;

  note_scroller #(
    .NUM_NOTES(N), .SPEED(SPEED), .SPAWN_X(SPAWN_X), .STAFF_TOP(STAFF_TOP),
    .HALF_SPACE(HALF_SPACE), .NOTE_W(NOTE_W), .NOTE_H(NOTE_H)
  ) dut (
    .Clk(Clk), .Reset(Reset), .vs(vs), .blank(blank), .DrawX(DrawX), .DrawY(DrawY),
    .note_valid(note_valid), .note_pitch(note_pitch), .note_ready(note_ready),
    .draw_note(draw_note), .active_count(active_count)
  );

  always #5 Clk = ~Clk;

  typedef struct {int x; int pitch;} note_t;
  typedef struct {bit chk_draw; bit draw; bit ready; bit chk_cnt; int cnt;} exp_t;

  note_t notes[$];
  exp_t  sb[$];
  int    busy = 0;
  bit    vs_prev = 1'b1;
  int    errors = 0;
  int    checks = 0;
  logic       drv_vs = 1'b1;
  logic       drv_nv = 1'b0;
  logic [3:0] drv_np = 4'd0;
  bit         last_accept;

  task automatic check(input bit ok, input string name, input int act, input int exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  function automatic bit model_hit(input int dx, input int dy);
    foreach (notes[i]) begin
      int yt;
      yt = STAFF_TOP + notes[i].pitch * HALF_SPACE;
      if (dx >= notes[i].x && dx < notes[i].x + NOTE_W && dy >= yt && dy < yt + NOTE_H)
        return 1'b1;
    end
    return 1'b0;
  endfunction

  // One frame's worth of scrolling: notes that cannot move a full step vanish.
  function automatic void frame_update();
    note_t kept[$];
    foreach (notes[i]) begin
      if (notes[i].x >= SPEED) kept.push_back('{notes[i].x - SPEED, notes[i].pitch});
    end
    notes = kept;
  endfunction

  // Drive one cycle of inputs and queue what the outputs must show after the edge.
  task automatic step(input int dx, input int dy, input bit bl);
    exp_t e;
    bit   pre_ready;
    bit   tick;
    @(negedge Clk);
    vs = drv_vs; blank = bl; DrawX = 10'(dx); DrawY = 10'(dy);
    note_valid = drv_nv; note_pitch = drv_np;
    e.chk_draw  = (busy == 0);
    e.draw      = bl && model_hit(dx, dy);
    pre_ready   = (busy == 0) && (notes.size() < N);
    last_accept = drv_nv && pre_ready;
    if (last_accept) notes.push_back('{SPAWN_X, int'(drv_np)});
    tick    = vs_prev && !drv_vs;
    vs_prev = drv_vs;
    if (busy > 0) busy--;
    else if (tick) begin
      busy = N + 1;
      frame_update();
    end
    e.ready   = (busy == 0) && (notes.size() < N);
    e.chk_cnt = (busy == 0);
    e.cnt     = notes.size();
    sb.push_back(e);
    if (last_accept) drv_np = 4'($urandom_range(0, 15));
  endtask

  // Random pixel, either anywhere on screen or close around a live note.
  task automatic probe_step(input bit near);
    int dx;
    int dy;
    bit bl;
    if (near && notes.size() > 0) begin
      int k;
      k  = int'($urandom_range(0, notes.size() - 1));
      dx = notes[k].x + int'($urandom_range(0, NOTE_W + 3)) - 2;
      dy = STAFF_TOP + notes[k].pitch * HALF_SPACE + int'($urandom_range(0, NOTE_H + 3)) - 2;
      if (dx < 0) dx = 0;
      if (dx > 1023) dx = 1023;
    end else begin
      dx = int'($urandom_range(0, 799));
      dy = int'($urandom_range(0, 524));
    end
    bl = ($urandom_range(0, 9) != 0);
    step(dx, dy, bl);
  endtask

  task automatic frame();
    drv_vs = 1'b0;
    repeat (3) probe_step(1'b1);
    drv_vs = 1'b1;
    repeat (N + 6) probe_step($urandom_range(0, 3) != 0);
  endtask

  // Monitor: one queued expectation per clock, sampled just after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge Clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        if (e.chk_draw) check(draw_note === e.draw, "draw_note", int'(draw_note), int'(e.draw));
        check(note_ready === e.ready, "note_ready", int'(note_ready), int'(e.ready));
        if (e.chk_cnt) check(int'(active_count) == e.cnt, "active_count", int'(active_count), e.cnt);
      end
    end
  end

  initial begin
    // Reset and release away from the clock edge.
    repeat (3) @(posedge Clk);
    check(note_ready === 1'b0, "ready_in_reset", int'(note_ready), 0);
    @(negedge Clk); #2;
    Reset = 1'b1;
    #1;
    check(note_ready === 1'b1, "ready_after_reset", int'(note_ready), 1);
    check(active_count == 5'd0, "count_after_reset", int'(active_count), 0);
    check(draw_note === 1'b0, "draw_after_reset", int'(draw_note), 0);

    // Empty table: nothing ever draws, including across a frame.
    repeat (150) probe_step(1'b0);
    frame();

    // One pitch-2 note at the spawn column, swept exhaustively around its head.
    drv_np = 4'd2; drv_nv = 1'b1;
    step(0, 0, 1'b1);
    drv_nv = 1'b0;
    for (int x = 636; x <= 647; x++)
      for (int y = 168; y <= 177; y++) step(x, y, 1'b1);
    for (int x = 638; x <= 646; x++) step(x, 172, 1'b0);

    // Three frames later the head spans 633..640.
    repeat (3) frame();
    for (int x = 630; x <= 642; x++) begin
      step(x, 172, 1'b1);
      step(x, 176, 1'b1);
    end

    // Scroll that note all the way out (...3, 1, retired).
    for (int f = 0; f < 400 && notes.size() > 0; f++) frame();
    repeat (20) probe_step(1'b0);

    // Fill the table back-to-back, stall the next note, then run until slots free.
    drv_nv = 1'b1;
    repeat (24) probe_step(1'b1);
    repeat (330) frame();
    drv_nv = 1'b0;
    repeat (3) frame();

    // Reset pulse in the middle of a scan.
    drv_nv = 1'b1;
    repeat (4) probe_step(1'b1);
    drv_vs = 1'b0;
    repeat (6) probe_step(1'b1);
    @(posedge Clk); #3;
    Reset = 1'b0;
    #1;
    check(active_count == 5'd0, "count_async_reset", int'(active_count), 0);
    check(draw_note === 1'b0, "draw_async_reset", int'(draw_note), 0);
    check(note_ready === 1'b0, "ready_async_reset", int'(note_ready), 0);
    notes.delete();
    busy = 0; vs_prev = 1'b1;
    drv_nv = 1'b0; drv_vs = 1'b1;
    vs = 1'b1; note_valid = 1'b0;
    repeat (2) @(posedge Clk);
    @(negedge Clk); #2;
    Reset = 1'b1;
    #1;
    check(note_ready === 1'b1, "ready_after_pulse", int'(note_ready), 1);

    // Life after the reset pulse.
    drv_nv = 1'b1;
    repeat (5) probe_step(1'b1);
    drv_nv = 1'b0;
    repeat (3) frame();
    repeat (10) probe_step(1'b0);

    repeat (3) @(posedge Clk);
    #2;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
